// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the three-way RAM port arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, ROMWP} state_e;

  typedef enum logic [1:0] {G_NONE, G_VID, G_CPU, G_LDR} gnt_e;

  localparam logic [17:0] VID_BASE = 18'h14000;
  localparam logic [17:0] ROM_TOP  = 18'h04000;

endpackage

// File: rtl/arb_slot.sv
// Request-capture slot: latches a one-cycle strobe with its payload, flags overruns.
module arb_slot #(
  parameter int unsigned PW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          set_i,
  input  logic          clr_i,
  input  logic [PW-1:0] payload_i,
  output logic          pending_o,
  output logic          overrun_o,
  output logic [PW-1:0] payload_o
);

  logic          pending_q, pending_d;
  logic          overrun_q, overrun_d;
  logic [PW-1:0] payload_q, payload_d;

  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    payload_d = payload_q;
    if (clr_i) pending_d = 1'b0;
    // A strobe landing on the completing cycle refills the slot instead of overrunning it.
    if (set_i) begin
      if (pending_q && !clr_i) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
        payload_d = payload_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      payload_q <= '0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      payload_q <= payload_d;
    end
  end

  assign pending_o = pending_q;
  assign overrun_o = overrun_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority (video > CPU > loader) arbiter for one byte-wide RAM port, with loader
// anti-starvation. Define MEM_ARBITER_ROMWP_EN to drop CPU writes below the ROM top.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned     AW      = 18,
  parameter logic [AW-1:0]   VIDBASE = AW'(VID_BASE),
  parameter int unsigned     LDMAX   = 15
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          vreq,
  input  logic [12:0]   va,
  output logic [7:0]    vq,
  output logic          vvalid,
  input  logic          creq,
  input  logic          cwe,
  input  logic [AW-1:0] ca,
  input  logic [7:0]    cd,
  output logic [7:0]    cq,
  output logic          cdone,
  input  logic          lreq,
  input  logic [AW-1:0] la,
  input  logic [7:0]    ld,
  output logic          ldone,
  output logic [2:0]    overrun,
  output logic          ramReq,
  output logic          ramWe,
  output logic [AW-1:0] ramA,
  output logic [7:0]    ramD,
  input  logic [7:0]    ramQ,
  input  logic          ramAck
);

  localparam int unsigned CW = $clog2(LDMAX + 2);

  logic          vid_pend, cpu_pend, ldr_pend;
  logic          vid_ovr, cpu_ovr, ldr_ovr;
  logic          vid_clr, cpu_clr, ldr_clr;
  logic [12:0]   vid_va;
  logic          cpu_we;
  logic [AW-1:0] cpu_a, ldr_a;
  logic [7:0]    cpu_d, ldr_d;

  arb_slot #(.PW(13)) u_vid_slot (
    .clk_i     (clock),
    .rst_i     (reset),
    .set_i     (vreq),
    .clr_i     (vid_clr),
    .payload_i (va),
    .pending_o (vid_pend),
    .overrun_o (vid_ovr),
    .payload_o (vid_va)
  );

  arb_slot #(.PW(AW + 9)) u_cpu_slot (
    .clk_i     (clock),
    .rst_i     (reset),
    .set_i     (creq),
    .clr_i     (cpu_clr),
    .payload_i ({cwe, ca, cd}),
    .pending_o (cpu_pend),
    .overrun_o (cpu_ovr),
    .payload_o ({cpu_we, cpu_a, cpu_d})
  );

  arb_slot #(.PW(AW + 8)) u_ldr_slot (
    .clk_i     (clock),
    .rst_i     (reset),
    .set_i     (lreq),
    .clr_i     (ldr_clr),
    .payload_i ({la, ld}),
    .pending_o (ldr_pend),
    .overrun_o (ldr_ovr),
    .payload_o ({ldr_a, ldr_d})
  );

  state_e        state_q, state_d;
  gnt_e          gnt_q, gnt_d, win;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ram_req_q, ram_req_d, ram_we_q, ram_we_d;
  logic [AW-1:0] ram_a_q, ram_a_d;
  logic [7:0]    ram_d_q, ram_d_d, cq_q, cq_d, vq_q, vq_d;
  logic          cdone_q, cdone_d, vvalid_q, vvalid_d, ldone_q, ldone_d;
  logic          rom_hit;

`ifdef MEM_ARBITER_ROMWP_EN
  assign rom_hit = cpu_we && (cpu_a < AW'(ROM_TOP));
`else
  assign rom_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    ram_req_d = ram_req_q;
    ram_we_d  = ram_we_q;
    ram_a_d   = ram_a_q;
    ram_d_d   = ram_d_q;
    cq_d      = cq_q;
    vq_d      = vq_q;
    cdone_d   = 1'b0;
    vvalid_d  = 1'b0;
    ldone_d   = 1'b0;
    vid_clr   = 1'b0;
    cpu_clr   = 1'b0;
    ldr_clr   = 1'b0;
    win       = G_NONE;

    unique case (state_q)
      IDLE: begin
        if (vid_pend) begin
          win = G_VID;
        end else if (ldr_pend && (cnt_q == CW'(LDMAX))) begin
          win   = G_LDR;
          cnt_d = '0;
        end else if (cpu_pend) begin
          win = G_CPU;
          if (ldr_pend && (cnt_q != CW'(LDMAX))) cnt_d = cnt_q + 1'b1;
        end else if (ldr_pend) begin
          win   = G_LDR;
          cnt_d = '0;
        end

        gnt_d = win;
        unique case (win)
          G_VID: begin
            ram_a_d   = VIDBASE + AW'(vid_va);
            ram_we_d  = 1'b0;
            ram_d_d   = '0;
            ram_req_d = 1'b1;
            state_d   = BUSY;
          end
          G_CPU: begin
            if (rom_hit) begin
              state_d = ROMWP;
            end else begin
              ram_a_d   = cpu_a;
              ram_we_d  = cpu_we;
              ram_d_d   = cpu_d;
              ram_req_d = 1'b1;
              state_d   = BUSY;
            end
          end
          G_LDR: begin
            ram_a_d   = ldr_a;
            ram_we_d  = 1'b1;
            ram_d_d   = ldr_d;
            ram_req_d = 1'b1;
            state_d   = BUSY;
          end
          default: ;
        endcase
      end
      BUSY: begin
        if (ramAck) begin
          ram_req_d = 1'b0;
          state_d   = IDLE;
          unique case (gnt_q)
            G_VID: begin
              vid_clr  = 1'b1;
              vvalid_d = 1'b1;
              vq_d     = ramQ;
            end
            G_CPU: begin
              cpu_clr = 1'b1;
              cdone_d = 1'b1;
              if (!ram_we_q) cq_d = ramQ;
            end
            G_LDR: begin
              ldr_clr = 1'b1;
              ldone_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ROMWP: begin
        cpu_clr = 1'b1;
        cdone_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= G_NONE;
      cnt_q     <= '0;
      ram_req_q <= 1'b0;
      ram_we_q  <= 1'b0;
      ram_a_q   <= '0;
      ram_d_q   <= '0;
      cq_q      <= '0;
      vq_q      <= '0;
      cdone_q   <= 1'b0;
      vvalid_q  <= 1'b0;
      ldone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      ram_req_q <= ram_req_d;
      ram_we_q  <= ram_we_d;
      ram_a_q   <= ram_a_d;
      ram_d_q   <= ram_d_d;
      cq_q      <= cq_d;
      vq_q      <= vq_d;
      cdone_q   <= cdone_d;
      vvalid_q  <= vvalid_d;
      ldone_q   <= ldone_d;
    end
  end

  assign ramReq  = ram_req_q;
  assign ramWe   = ram_we_q;
  assign ramA    = ram_a_q;
  assign ramD    = ram_d_q;
  assign cq      = cq_q;
  assign vq      = vq_q;
  assign cdone   = cdone_q;
  assign vvalid  = vvalid_q;
  assign ldone   = ldone_q;
  assign overrun = {ldr_ovr, cpu_ovr, vid_ovr};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; ROM write-protect steps follow
// MEM_ARBITER_ROMWP_EN.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        vreq, creq, cwe, lreq, ramAck;
  logic [12:0] va;
  logic [17:0] ca, la;
  logic [7:0]  cd, ld, ramQ;
  logic [7:0]  vq, cq, ramD;
  logic        vvalid, cdone, ldone, ramReq, ramWe;
  logic [2:0]  overrun;
  logic [17:0] ramA;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter dut (
    .clock   (clock),
    .reset   (reset),
    .vreq    (vreq),
    .va      (va),
    .vq      (vq),
    .vvalid  (vvalid),
    .creq    (creq),
    .cwe     (cwe),
    .ca      (ca),
    .cd      (cd),
    .cq      (cq),
    .cdone   (cdone),
    .lreq    (lreq),
    .la      (la),
    .ld      (ld),
    .ldone   (ldone),
    .overrun (overrun),
    .ramReq  (ramReq),
    .ramWe   (ramWe),
    .ramA    (ramA),
    .ramD    (ramD),
    .ramQ    (ramQ),
    .ramAck  (ramAck)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; vreq = 0; creq = 0; cwe = 0; lreq = 0; ramAck = 0;
    va = '0; ca = '0; la = '0; cd = '0; ld = '0; ramQ = '0;
    tick(); tick();
    check("rst_ramreq", {31'd0, ramReq}, 32'd0);
    check("rst_pulses", {29'd0, cdone, vvalid, ldone}, 32'd0);
    check("rst_overrun", {29'd0, overrun}, 32'd0);
    check("rst_data", {8'd0, cq, vq, ramD}, 32'd0);
    check("rst_addr", {13'd0, ramWe, ramA}, 32'd0);
    reset = 1'b0;
    tick();

    // Single CPU read
    creq = 1; ca = 18'h05000; cwe = 0;
    tick();
    creq = 0;
    check("cpu_rd_latency1", {31'd0, ramReq}, 32'd0);
    tick();
    check("cpu_rd_req", {31'd0, ramReq}, 32'd1);
    check("cpu_rd_addr", {13'd0, ramWe, ramA}, {14'd0, 18'h05000});
    tick(); tick();
    check("cpu_rd_hold", {13'd0, ramReq, ramA}, {14'd1, 18'h05000});
    ramAck = 1; ramQ = 8'hA5;
    tick();
    ramAck = 0;
    check("cpu_rd_done", {23'd0, cdone, cq}, {23'd1, 8'hA5});
    check("cpu_rd_reqlow", {31'd0, ramReq}, 32'd0);
    // Stray ack while idle must do nothing
    ramAck = 1; ramQ = 8'h00;
    tick();
    ramAck = 0;
    check("idle_ack_ignored", {20'd0, cdone, vvalid, ldone, ramReq, cq}, {24'd0, 8'hA5});
    tick();

    // Video beats CPU when both strobe together
    vreq = 1; va = 13'h0010; creq = 1; ca = 18'h00200; cwe = 1; cd = 8'h5A;
    tick();
    vreq = 0; creq = 0;
    tick();
    check("vid_first_addr", {13'd0, ramWe, ramA}, {14'd0, 18'h14010});
    ramAck = 1; ramQ = 8'h3C;
    tick();
    ramAck = 0;
    check("vid_valid", {22'd0, vvalid, cdone, vq}, {22'd2, 8'h3C});
    check("vid_gap", {31'd0, ramReq}, 32'd0);
    tick();
    check("cpu_after_vid", {5'd0, ramReq, ramWe, ramD, ramA}, {5'd0, 2'b11, 8'h5A, 18'h00200});
    ramAck = 1;
    tick();
    ramAck = 0;
    check("cpu_wr_done", {23'd0, cdone, cq}, {23'd1, 8'hA5});
    tick();

    // Overrun: second CPU strobe before service is dropped
    creq = 1; ca = 18'h00300; cwe = 1; cd = 8'h11;
    tick();
    ca = 18'h00301; cd = 8'h22;
    tick();
    creq = 0;
    check("ovr_flag", {29'd0, overrun}, 32'd2);
    check("ovr_payload", {6'd0, ramD, ramA}, {6'd0, 8'h11, 18'h00300});
    ramAck = 1;
    tick();
    ramAck = 0;
    check("ovr_done", {31'd0, cdone}, 32'd1);
    tick();
    check("ovr_no_second", {28'd0, ramReq, overrun}, 32'd2);

    // Loader anti-starvation: 15 CPU grants, then the loader
    lreq = 1; la = 18'h00400; ld = 8'h77;
    creq = 1; ca = 18'h00500; cwe = 0;
    tick();
    lreq = 0; creq = 0;
    tick();
    for (int i = 0; i < 15; i++) begin
      check($sformatf("starve_cpu%0d", i), {13'd0, ramReq, ramA}, {14'd1, 18'h00500});
      ramAck = 1; ramQ = 8'(i); creq = 1;
      tick();
      ramAck = 0; creq = 0;
      check($sformatf("starve_cdone%0d", i), {23'd0, cdone, cq}, {23'd1, 8'(i)});
      tick();
    end
    check("starve_ldr_grant", {5'd0, ramReq, ramWe, ramD, ramA}, {5'd0, 2'b11, 8'h77, 18'h00400});
    ramAck = 1; lreq = 1;
    tick();
    ramAck = 0; lreq = 0;
    check("starve_ldone", {30'd0, ldone, cdone}, 32'd2);
    tick();
    check("starve_repeat_cpu", {13'd0, ramReq, ramA}, {14'd1, 18'h00500});

    // Reset in the middle of the access abandons it
    reset = 1;
    tick();
    reset = 0;
    check("rst_mid_ramreq", {29'd0, ramReq, cdone, ldone}, 32'd0);
    check("rst_mid_overrun", {29'd0, overrun}, 32'd0);
    tick(); tick();
    check("rst_mid_no_pending", {30'd0, ramReq, cdone}, 32'd0);
    creq = 1; ca = 18'h00600; cwe = 0;
    tick();
    creq = 0;
    tick();
    check("post_rst_req", {13'd0, ramReq, ramA}, {14'd1, 18'h00600});
    ramAck = 1; ramQ = 8'hC3;
    tick();
    ramAck = 0;
    check("post_rst_done", {23'd0, cdone, cq}, {23'd1, 8'hC3});
    tick();

    // CPU write into the ROM region
    creq = 1; ca = 18'h00100; cwe = 1; cd = 8'h99;
    tick();
    creq = 0;
    tick();
`ifdef MEM_ARBITER_ROMWP_EN
    check("romwp_no_req", {31'd0, ramReq}, 32'd0);
    tick();
    check("romwp_cdone", {22'd0, ramReq, cdone, cq}, {22'd1, 8'hC3});
    tick();
    check("romwp_cdone_pulse", {30'd0, ramReq, cdone}, 32'd0);
`else
    check("rom_wr_issued", {5'd0, ramReq, ramWe, ramD, ramA}, {5'd0, 2'b11, 8'h99, 18'h00100});
    ramAck = 1;
    tick();
    ramAck = 0;
    check("rom_wr_done", {23'd0, cdone, cq}, {23'd1, 8'hC3});
    tick();
`endif
    // Loader writes to the ROM region always reach RAM
    lreq = 1; la = 18'h00100; ld = 8'h44;
    tick();
    lreq = 0;
    tick();
    check("ldr_rom_wr", {5'd0, ramReq, ramWe, ramD, ramA}, {5'd0, 2'b11, 8'h44, 18'h00100});
    ramAck = 1;
    tick();
    ramAck = 0;
    check("ldr_rom_done", {31'd0, ldone}, 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one byte-wide RAM port (the memory controller's request/acknowledge interface) between three requesters: video fetch, Z80 CPU and a tape/snapshot loader.
- Latches each requester's single-cycle strobe and grants by fixed priority, video > CPU > loader. Drives one access at a time and routes the read data back to the requester that issued it.
- Sits between the CPU/VDU/loader and the memory block, all in the 28 MHz domain.

Parameters:
AW, 18, RAM byte-address width
VIDBASE, 18'h14000, RAM base added to the 13-bit video address
LDMAX, 15, CPU grants allowed in a row while the loader is pending before the loader is forced first

Ports:
clock  in  1  system clock (28 MHz)
reset  in  1  synchronous reset, active-high
vreq  in  1  video strobe, one cycle
va  in  13  video address (offset from VIDBASE)
vq  out  8  video read data
vvalid  out  1  one-cycle pulse, vq valid
creq  in  1  CPU strobe, one cycle
cwe  in  1  CPU write when 1
ca  in  AW  CPU address
cd  in  8  CPU write data
cq  out  8  CPU read data
cdone  out  1  one-cycle pulse, CPU access complete
lreq  in  1  loader strobe, one cycle
la  in  AW  loader address (always a write)
ld  in  8  loader write data
ldone  out  1  one-cycle pulse, loader write complete
overrun  out  3  sticky {loader, cpu, video}; strobe arrived while that requester was already pending
ramReq  out  1  access request, held until ramAck
ramWe  out  1  write enable
ramA  out  AW  address
ramD  out  8  write data
ramQ  in  8  read data, valid with ramAck
ramAck  in  1  one-cycle completion pulse

Behaviour:
- Reset values: every output 0; all pending bits, overrun and the LDMAX counter cleared; state IDLE. Reset asserted mid-access abandons the access immediately (ramReq drops the next cycle), with no done or valid pulse.
- Capture: on xreq the address, data and we are copied into that requester's slot and its pending bit is set.
  - If the slot is already pending, the strobe is ignored, the slot is unchanged and the overrun bit sets. The overrun bit clears only on reset.
- States:
  - IDLE: if any slot is pending, pick a winner, load ramA/ramWe/ramD, assert ramReq, go to BUSY.
  - BUSY: hold ramReq and all ram outputs stable until ramAck. On ramAck drop ramReq, clear the winner's pending bit, pulse its done/valid, go to IDLE.
  - Minimum one idle cycle between accesses.
- Arbitration order:
  - Video pending wins.
  - Else, if the loader is pending and the counter equals LDMAX, the loader wins and the counter clears.
  - Else the CPU wins if pending; the counter increments (saturating) only when the loader is also pending.
  - Else the loader wins and the counter clears.
- Video address: ramA = VIDBASE + va, zero-extended to AW, wrapping mod 2^AW. Video is always a read.
- Read data:
  - On a CPU read, cq is registered from ramQ on ramAck and held until the next CPU completion.
  - vq behaves the same way for video reads.
  - On a CPU write, cq is unchanged.
- Same-cycle cases:
  - A strobe that arrives in the same cycle its own slot completes is captured as a new pending request; no overrun.
  - Strobes from different requesters in the same cycle are all captured.
- Latency: from strobe to ramReq is 2 cycles (capture, then IDLE decision) when the port is free. Done or valid pulses the cycle after ramAck.
- ramAck seen in IDLE is ignored.

Optional Feature:
- Macro: MEM_ARBITER_ROMWP_EN.
- Defined: a CPU write with ca < 18'h04000 is never issued to RAM. It completes in a 1-cycle pseudo-access with cdone pulsed and cq unchanged. It still counts as a CPU grant for the LDMAX counter. Loader writes to that region pass through unchanged.
- Undefined: all CPU writes are issued.

Decomposition:
- Package mem_arbiter_pkg holds:
  - the state enum {IDLE, BUSY, ROMWP};
  - the grant-id enum {G_NONE, G_VID, G_CPU, G_LDR};
  - the VIDBASE default and the ROM-top constant 18'h04000.
- One sub-module, arb_slot: a request-capture register with pending bit, overrun flag and payload. It is instantiated three times.

Test Plan:
- Single CPU read: creq ca=18'h05000, cwe=0; model ramAck after 3 cycles with ramQ=8'hA5 → ramA=18'h05000, ramWe=0; cq=8'hA5 with cdone 1 cycle after ack; ramReq low after ack.
- Video priority: vreq va=13'h0010 and creq in the same cycle → first ramA=18'h14010 and vvalid first; CPU access follows, separated by ≥1 idle cycle.
- Loader anti-starvation: loader held pending while creq is reissued on every cdone → exactly 15 CPU grants, then 1 loader grant (ldone), then the pattern repeats.
- Overrun: creq twice before service → overrun=3'b010; the second payload is discarded (ramD equals the first cd); overrun stays set until reset.
- Reset mid-access: reset asserted while in BUSY → ramReq=0 next cycle, no cdone, all pending bits clear; a subsequent creq is serviced normally.
- MEM_ARBITER_ROMWP_EN defined: CPU write ca=18'h00100 → no ramReq, cdone 1 cycle after the IDLE decision; loader write la=18'h00100 → ramReq with ramWe=1.
